// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and width helpers for the UART transmit arbiter
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first set req bit after ptr, with wrap-around
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate so bit 0 is the requester just after ptr; lowest set bit wins.
        rot = NUM_REQ'({req, req} >> ({1'b0, ptr} + (IDX_W+1)'(1)));
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off} + (IDX_W+1)'(1);
        if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
        valid = |req;
        idx   = sum[IDX_W-1:0];
        pick  = valid ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one uart_tx between NUM_REQ byte requesters
// Optional WAIT_DONE abort counter enabled by macro UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_data,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic                            o_tx_start,
    output logic [DATA_WIDTH-1:0]           o_tx_data,
    input  logic                            i_tx_done,
    output logic                            o_busy,
    output logic [idx_width(NUM_REQ)-1:0]   o_grant_id,
    output logic                            o_timeout
);

    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state, state_next;
    logic [IDX_W-1:0]       ptr, ptr_next, grant_id_next;
    logic [NUM_REQ-1:0]     grant_next, pick;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   start_next;
    logic [DATA_WIDTH-1:0]  data_next;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   timeout_q, timeout_next;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (i_req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        grant_id_next = o_grant_id;
        grant_next    = '0;
        start_next    = 1'b0;
        data_next     = o_tx_data;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_next      = cnt;
        timeout_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next    = START;
                    ptr_next      = pick_idx;
                    grant_id_next = pick_idx;
                    grant_next    = pick;
                    data_next     = i_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            START: begin
                state_next = WAIT_DONE;
                start_next = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            WAIT_DONE: begin
                // Done has priority over a timeout landing on the same cycle.
                if (i_tx_done) begin
                    state_next = IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            o_grant    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_grant_id <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt        <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            o_grant    <= grant_next;
            o_tx_start <= start_next;
            o_tx_data  <= data_next;
            o_busy     <= (state_next != IDLE);
            o_grant_id <= grant_id_next;
`ifdef UART_ARB_TIMEOUT_EN
            cnt        <= cnt_next;
            timeout_q  <= timeout_next;
`endif
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed bench for uart_tx_arbiter against a timeline model
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 50;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   i_req = '0;
    logic [N*W-1:0] i_data = '0;
    logic           i_tx_done = 1'b0;
    logic [N-1:0]   o_grant;
    logic           o_tx_start;
    logic [W-1:0]   o_tx_data;
    logic           o_busy;
    logic [1:0]     o_grant_id;
    logic           o_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_WIDTH     (W),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_data     (i_data),
        .o_grant    (o_grant),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_grant_id (o_grant_id),
        .o_timeout  (o_timeout)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: last served index, whether a frame is in flight, and the grant edge.
    int           m_last;
    int           m_active;
    int           m_gedge;
    int           m_id;
    logic [W-1:0] m_data;
    int           e = 0;
    int           order[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last   = N - 1;
        m_active = 0;
        m_gedge  = 0;
        m_id     = 0;
        m_data   = '0;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic dn);
        int           k;
        logic [N-1:0] eg;
        logic         es;
        logic         et;
        i_req     = r;
        i_data    = d;
        i_tx_done = dn;
        @(posedge clk);
        e++;
        eg = '0;
        es = 1'b0;
        et = 1'b0;
        if (m_active == 0) begin
            if (r != 0) begin
                k = -1;
                for (int i = 1; i <= N; i++) begin
                    if (k < 0 && r[(m_last + i) % N]) k = (m_last + i) % N;
                end
                eg[k]    = 1'b1;
                m_id     = k;
                m_last   = k;
                m_data   = d[k*W +: W];
                m_active = 1;
                m_gedge  = e;
            end
        end else if (e == m_gedge + 1) begin
            es = 1'b1;
        end else if (dn) begin
            m_active = 0;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (e == m_gedge + 1 + TO) begin
            et       = 1'b1;
            m_active = 0;
        end
`endif
        #1;
        check("grant",    32'(o_grant),    32'(eg));
        check("tx_start", 32'(o_tx_start), 32'(es));
        check("tx_data",  32'(o_tx_data),  32'(m_data));
        check("busy",     32'(o_busy),     32'(m_active != 0));
        check("grant_id", 32'(o_grant_id), 32'(m_id));
        check("timeout",  32'(o_timeout),  32'(et));
        if (o_grant != 0) order.push_back(int'(o_grant_id));
    endtask

    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_grant",    32'(o_grant),    32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_data",  32'(o_tx_data),  32'd0);
        check("rst_busy",     32'(o_busy),     32'd0);
        check("rst_grant_id", 32'(o_grant_id), 32'd0);
        check("rst_timeout",  32'(o_timeout),  32'd0);
        model_reset();
        i_req     = '0;
        i_tx_done = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Holds r until nframes grants are seen, answering each start with done after dly cycles.
    task automatic run_frames(input logic [N-1:0] r, input logic [N*W-1:0] d,
                              input int nframes, input int dly);
        int   seen;
        int   since;
        int   guard;
        logic dn;
        seen  = 0;
        since = -1;
        guard = 0;
        while (seen < nframes && guard < 2000) begin
            dn = (since == dly);
            cycle(r, d, dn);
            if (o_grant != 0) seen++;
            if (dn) since = -1;
            if (o_tx_start) since = 0;
            else if (since >= 0) since++;
            guard++;
        end
        check("frames_seen", seen, nframes);
    endtask

    task automatic finish_frame(input logic [N*W-1:0] d);
        for (int i = 0; i < 3; i++) cycle('0, d, 1'b0);
        cycle('0, d, 1'b1);
        for (int i = 0; i < 3; i++) cycle('0, d, 1'b0);
    endtask

    task automatic check_order(input int exp_order[$]);
        check("order_len", order.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < order.size(); i++)
            check("order", order[i], exp_order[i]);
        order.delete();
    endtask

    logic [N*W-1:0] bytes_rr;
    logic [N*W-1:0] bytes_one;
    logic [N-1:0]   mask;

    initial begin
        bytes_rr  = {8'h13, 8'h12, 8'h11, 8'h10};
        bytes_one = {8'h00, 8'hDA, 8'h00, 8'h00};
        #1;
        apply_reset();

        run_frames(4'b0100, bytes_one, 1, 5);
        finish_frame(bytes_one);
        check_order('{2});

        apply_reset();
        run_frames(4'b1111, bytes_rr, 5, 20);
        check_order('{0, 1, 2, 3, 0});
        run_frames(4'b1111, bytes_rr, 3, 20);
        run_frames(4'b1010, bytes_rr, 2, 20);
        finish_frame(bytes_rr);
        check_order('{1, 2, 3, 1, 3});

        run_frames(4'b0010, bytes_rr, 1, 30);
        for (int i = 0; i < 3; i++) cycle(4'b0001, bytes_rr, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, bytes_rr, 1'b0);
        finish_frame(bytes_rr);
        check_order('{1});

        run_frames(4'b0010, bytes_rr, 1, 50);
        for (int i = 0; i < 4; i++) cycle(4'b0000, bytes_rr, 1'b0);
        apply_reset();
        run_frames(4'b1000, bytes_rr, 1, 5);
        finish_frame(bytes_rr);
        apply_reset();
        run_frames(4'b1001, bytes_rr, 1, 5);
        finish_frame(bytes_rr);
        check_order('{1, 3, 0});

`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 2 * TO + 20; i++) cycle(4'b0011, bytes_rr, 1'b0);
        for (int i = 0; i < 4; i++) cycle(4'b0000, bytes_rr, 1'b0);
        apply_reset();
`endif

        mask = '1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) mask = N'($urandom_range(1, (1 << N) - 1));
            cycle(N'($urandom) & mask, {$urandom}, ($urandom_range(0, 5) == 0));
            if (c == 2000) apply_reset();
        end
        order.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single uart_tx transmitter between NUM_REQ byte requesters using round-robin arbitration. The arbiter captures the granted requester's byte and issues a one-cycle start pulse to uart_tx. It then holds off further grants until uart_tx reports o_tx_done. It sits between the client blocks (uart_rx echo path, status reporters, etc.) and uart_tx, all on the same clk as br_generator.

Parameters:
DATA_WIDTH, 8, bits per UART byte; must match uart_tx DATA_WIDTH
NUM_REQ, 4, number of requesters; legal range 2..8
TIMEOUT_CYCLES, 2_000_000, clk cycles allowed in WAIT_DONE before abort; used only with the optional feature

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
i_req  input  NUM_REQ  per-requester request; held high until the matching o_grant bit
i_data  input  NUM_REQ*DATA_WIDTH  requester bytes; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
o_grant  output  NUM_REQ  one-hot, one-cycle pulse; byte of that requester captured
o_tx_start  output  1  one-cycle pulse to uart_tx i_tx_signal
o_tx_data  output  DATA_WIDTH  byte to uart_tx i_data_byte; stable from grant until done
i_tx_done  input  1  uart_tx o_tx_done pulse
o_busy  output  1  high in any state other than IDLE
o_grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester
o_timeout  output  1  one-cycle abort pulse (optional feature only; otherwise tied 0)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, o_grant=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_grant_id=0, o_timeout=0, rr pointer=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE, START, WAIT_DONE. All outputs are registered.
- IDLE: if |i_req, select the first set bit scanning upward from (ptr+1) mod NUM_REQ, with wrap-around. On the next edge:
  - latch o_tx_data = that requester's byte;
  - o_grant[k]=1 for one cycle;
  - o_grant_id=k, ptr=k;
  - go to START.
- START: o_tx_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: hold o_tx_data. When i_tx_done=1, go to IDLE. No grants are issued while in this state.
- Latency: i_req sampled high at edge N gives o_grant at N+1 and o_tx_start at N+2. After i_tx_done sampled at edge M, the earliest next grant is at M+2, giving one IDLE cycle minimum.
- A requester dropping i_req before its grant is skipped with no side effects. Requests arriving during START or WAIT_DONE wait for IDLE.
- Simultaneous requests: strict round-robin. A requester that is just served has lowest priority on the next arbitration.
- A single persistent requester is re-granted on every IDLE pass.
- i_tx_done seen in IDLE or START is ignored.
- Reset asserted mid-frame aborts immediately to reset values. uart_tx shares reset, so no orphan frame remains.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_DONE and increments each cycle there. When the counter reaches TIMEOUT_CYCLES without i_tx_done:
  - o_timeout pulses for one cycle;
  - the FSM returns to IDLE;
  - ptr is kept at k, so k loses priority.
  If i_tx_done arrives on the same cycle as the limit, done wins and there is no timeout pulse.
- Undefined: no counter is built, o_timeout is constant 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, WAIT_DONE);
  - DATA_WIDTH default constant;
  - localparam helpers for the index width.
- Sub-module rr_picker: purely combinational, takes req vector and ptr, returns one-hot pick plus index. It is reusable for a future RX-side dispatcher.

Test Plan:
- Single request: i_req=4'b0100, byte2=8'hDA → o_grant=4'b0100 one cycle later, o_tx_start next cycle, o_tx_data=8'hDA held until a stub i_tx_done pulse, then o_busy=0.
- Round-robin fairness: i_req=4'b1111 held, bytes 8'h10..8'h13, done stubbed 20 cycles after each start → grant order 0,1,2,3,0; exactly one o_tx_start per grant.
- Wrap and skip: ptr=3 after a grant to requester 3, then i_req=4'b1010 → next grant is 1, then 3.
- Withdrawn request: i_req[0] raised and dropped during WAIT_DONE → never granted, no extra o_tx_start.
- Reset mid-frame: reset=0 in WAIT_DONE → all outputs 0 asynchronously. After release with i_req=4'b1000, requester 3 is granted, and requester 0 wins if both 0 and 3 request.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50, done never asserted → o_timeout pulses 50 cycles after WAIT_DONE entry, FSM returns to IDLE, and the next grant goes to a different pending requester.
